// File: rtl/data_sync_filter.sv
// -----------------------------------------------------------------------------
// data_sync_filter
//
// Per-bit clock-domain-crossing synchroniser followed by a per-bit stability
// filter. Each input bit runs through an S_DEPTH flop chain. The filtered
// output bit follows the synchronised value only after that value has
// differed from the output for F_DEPTH consecutive cycles. Short glitches are
// discarded, and interrupted runs never accumulate.
//
// Parameters:
//   D_WIDTH  number of independent bit channels
//   S_DEPTH  synchroniser stages per bit (>= 2)
//   F_DEPTH  cycles a new value must persist (>= 1, 1 = no filtering)
//   RST_VAL  reset value of the sync chain and data_o
//
// Ports:
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset
//   data_i   asynchronous input bus, bits independent
//   data_o   synchronised, filtered bus (registered)
//   rise_o   one-cycle pulse per bit when data_o goes 0->1
//   fall_o   one-cycle pulse per bit when data_o goes 1->0
//
// Optional feature macro: DATA_SYNC_FILTER_EDGE_EN
//   defined   : rise_o/fall_o are registered edge pulses aligned with data_o
//   undefined : rise_o/fall_o are tied to 0 and no edge logic is built
// -----------------------------------------------------------------------------
module data_sync_filter #(
  parameter int unsigned         D_WIDTH = 8,
  parameter int unsigned         S_DEPTH = 2,
  parameter int unsigned         F_DEPTH = 4,
  parameter logic [D_WIDTH-1:0]  RST_VAL = {D_WIDTH{1'b0}}
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [D_WIDTH-1:0] data_i,
  output logic [D_WIDTH-1:0] data_o,
  output logic [D_WIDTH-1:0] rise_o,
  output logic [D_WIDTH-1:0] fall_o
);

  localparam int unsigned     CW       = $clog2(F_DEPTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(F_DEPTH - 1);

  // r_sync[0] samples data_i; r_sync[S_DEPTH-1] is the synchronised value.
  logic [S_DEPTH-1:0][D_WIDTH-1:0] r_sync;
  logic [D_WIDTH-1:0]              w_sync;
  logic [D_WIDTH-1:0]              r_data;
  logic [D_WIDTH-1:0][CW-1:0]      r_cnt;

  logic [D_WIDTH-1:0]              w_diff;
  logic [D_WIDTH-1:0]              w_take;
  logic [D_WIDTH-1:0]              w_data_nxt;
  logic [D_WIDTH-1:0][CW-1:0]      w_cnt_nxt;

  // ---------------------------------------------------------------------------
  // Synchroniser chain
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= {S_DEPTH{RST_VAL}};
    end else begin
      r_sync <= {r_sync[S_DEPTH-2:0], data_i};
    end
  end

  assign w_sync = r_sync[S_DEPTH-1];

  // ---------------------------------------------------------------------------
  // Stability filter
  // The counter holds how many consecutive cycles w_sync has already differed
  // from data_o; the F_DEPTH-th differing cycle commits the new value. Any
  // cycle where they agree clears the count, so glitches never accumulate.
  // With F_DEPTH=1, CNT_LAST is 0 and every difference commits immediately,
  // leaving the counters at a constant 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_diff     = '0;
    w_take     = '0;
    w_data_nxt = r_data;
    w_cnt_nxt  = r_cnt;
    for (int b = 0; b < int'(D_WIDTH); b++) begin
      w_diff[b] = w_sync[b] ^ r_data[b];
      w_take[b] = w_diff[b] && (r_cnt[b] == CNT_LAST);
      if (!w_diff[b] || w_take[b]) begin
        w_cnt_nxt[b] = '0;
      end else begin
        w_cnt_nxt[b] = r_cnt[b] + CW'(1);
      end
      if (w_take[b]) begin
        w_data_nxt[b] = w_sync[b];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data <= RST_VAL;
      r_cnt  <= '0;
    end else begin
      r_data <= w_data_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign data_o = r_data;

  // ---------------------------------------------------------------------------
  // Edge pulses: registered on the same edge that commits data_o, so the pulse
  // and the new data_o value appear in the same cycle. A commit always flips
  // the bit, so the committed value alone tells the direction.
  // ---------------------------------------------------------------------------
`ifdef DATA_SYNC_FILTER_EDGE_EN
  logic [D_WIDTH-1:0] r_rise;
  logic [D_WIDTH-1:0] r_fall;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_take & w_sync;
      r_fall <= w_take & ~w_sync;
    end
  end

  assign rise_o = r_rise;
  assign fall_o = r_fall;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

// File: tb/tb_data_sync_filter.sv
// -----------------------------------------------------------------------------
// tb_data_sync_filter
//
// Directed and randomised stimulus for data_sync_filter. Two instances:
//   u_dut   : defaults (D_WIDTH=8, S_DEPTH=2, F_DEPTH=4, RST_VAL=0)
//   u_sweep : D_WIDTH=1, S_DEPTH=3, F_DEPTH=1
// The reference model states the filter as a window rule: after edge n, a
// bit of data_o equals v if the last F_DEPTH synchronised samples (data_i
// sampled at edges n-S_DEPTH-F_DEPTH+1 .. n-S_DEPTH) were all v, otherwise
// it keeps its previous value. The sweep instance is modelled as a pure
// 4-edge delay of its input.
// -----------------------------------------------------------------------------
module tb_data_sync_filter;

  localparam int DW  = 8;
  localparam int SD  = 2;
  localparam int FD  = 4;
  localparam logic [DW-1:0] RV = '0;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rst2_n = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [DW-1:0] dout, rise, fall;
  logic [0:0]    din2  = '0;
  logic [0:0]    dout2, rise2, fall2;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] hist[$];
  logic [DW-1:0] m_out  = RV;
  logic [DW-1:0] m_rise = '0;
  logic [DW-1:0] m_fall = '0;
  logic [0:0]    q2[$];
  logic [0:0]    m2_out  = '0;
  logic [0:0]    m2_rise = '0;
  logic [0:0]    m2_fall = '0;
  int            hold    = 0;
  int            hold2   = 0;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  data_sync_filter #(
    .D_WIDTH (DW),
    .S_DEPTH (SD),
    .F_DEPTH (FD),
    .RST_VAL (RV)
  ) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .data_i  (din),
    .data_o  (dout),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  data_sync_filter #(
    .D_WIDTH (1),
    .S_DEPTH (3),
    .F_DEPTH (1),
    .RST_VAL (1'b0)
  ) u_sweep (
    .clk_i   (clk),
    .rst_n_i (rst2_n),
    .data_i  (din2),
    .data_o  (dout2),
    .rise_o  (rise2),
    .fall_o  (fall2)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  task automatic model_reset();
    hist.delete();
    repeat (SD + FD) hist.push_back(RV);
    m_out  = RV;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_edge(input logic [DW-1:0] sample);
    logic [DW-1:0] all_one;
    logic [DW-1:0] any_one;
    logic [DW-1:0] nxt;
    int            last;
    if (hist.size() > SD + FD) void'(hist.pop_front());
    hist.push_back(sample);
    last    = hist.size() - 1;
    all_one = '1;
    any_one = '0;
    for (int k = 0; k < FD; k++) begin
      all_one &= hist[last - SD - k];
      any_one |= hist[last - SD - k];
    end
    // unanimous 1 -> 1, unanimous 0 -> 0, mixed -> hold
    nxt = all_one | (m_out & any_one);
`ifdef DATA_SYNC_FILTER_EDGE_EN
    m_rise = ~m_out & nxt;
    m_fall = m_out & ~nxt;
`else
    m_rise = '0;
    m_fall = '0;
`endif
    m_out = nxt;
  endtask

  task automatic model2_edge(input logic [0:0] sample);
    logic [0:0] nxt;
    if (q2.size() > 8) void'(q2.pop_front());
    q2.push_back(sample);
    nxt = q2[q2.size() - 4];
`ifdef DATA_SYNC_FILTER_EDGE_EN
    m2_rise = ~m2_out & nxt;
    m2_fall = m2_out & ~nxt;
`else
    m2_rise = '0;
    m2_fall = '0;
`endif
    m2_out = nxt;
  endtask

  // One clock: update models with the values present at the edge, check all
  // outputs 1 time unit later, then advance the sweep instance's stimulus.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(din);
    if (rst2_n) model2_edge(din2);
    #1;
    check("data_o", dout, m_out);
    check("rise_o", rise, m_rise);
    check("fall_o", fall, m_fall);
    check("sweep_data_o", DW'(dout2), DW'(m2_out));
    check("sweep_rise_o", DW'(rise2), DW'(m2_rise));
    check("sweep_fall_o", DW'(fall2), DW'(m2_fall));
    if (hold2 == 0) begin
      din2  = 1'($urandom_range(0, 1));
      hold2 = $urandom_range(2, 5);
    end
    hold2--;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    repeat (3) q2.push_back(1'b0);

    // Reset held 3 cycles; outputs at RST_VAL
    repeat (3) tick();
    check("reset_data_o", dout, 8'h00);

    // Release and drive A5: data_o updates on edge 6, rise pulse one cycle
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    din    = 8'hA5;
    repeat (5) tick();
    check("lat_before_edge6", dout, 8'h00);
    check("no_pulse_release", rise | fall, 8'h00);
    tick();
    check("lat_at_edge6", dout, 8'hA5);
`ifdef DATA_SYNC_FILTER_EDGE_EN
    check("rise_at_edge6", rise, 8'hA5);
`endif
    tick();
    check("rise_one_cycle", rise, 8'h00);

    // Glitch rejection: 3-cycle pulse on bit 0 is dropped
    din = 8'h00;
    repeat (10) tick();
    din[0] = 1'b1;
    repeat (3) tick();
    din[0] = 1'b0;
    repeat (8) tick();
    check("glitch_3_rejected", dout, 8'h00);
    // 4-cycle pulse is accepted on edge 6
    din[0] = 1'b1;
    repeat (4) tick();
    din[0] = 1'b0;
    repeat (2) tick();
    check("pulse_4_accepted", dout, 8'h01);
    repeat (8) tick();
    check("pulse_4_returns", dout, 8'h00);

    // Repeated 3-high / 1-low glitches on bit 3 never accumulate
    for (int i = 0; i < 10; i++) begin
      din[3] = 1'b1;
      repeat (3) tick();
      din[3] = 1'b0;
      tick();
      check("repeat_glitch", dout, 8'h00);
    end
    repeat (6) tick();

    // Fall edges and independence: bit 7, then bit 0 two cycles later
    din = 8'hFF;
    repeat (10) tick();
    check("all_ones", dout, 8'hFF);
    din[7] = 1'b0;
    repeat (2) tick();
    din[0] = 1'b0;
    repeat (4) tick();
    check("fall_bit7", dout, 8'h7F);
`ifdef DATA_SYNC_FILTER_EDGE_EN
    check("fall_o_bit7", fall, 8'h80);
`endif
    repeat (2) tick();
    check("fall_bit0", dout, 8'h7E);
`ifdef DATA_SYNC_FILTER_EDGE_EN
    check("fall_o_bit0", fall, 8'h01);
`endif
    tick();
    check("fall_one_cycle", fall, 8'h00);

    // Reset mid-count: bit 2 counter at 2 when reset asserts
    din = 8'hFB;
    repeat (10) tick();
    check("pre_reset", dout, 8'hFB);
    din[2] = 1'b1;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_data_o", dout, 8'h00);
    check("async_reset_edges", rise | fall, 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_reset_latency", dout, 8'h00);
    tick();
    check("post_reset_update", dout, 8'hFF);

    // Randomised traffic: holds of 1..8 cycles mix glitches and real changes
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 1) din = DW'($urandom);
        else                           din = din ^ (DW'(1) << $urandom_range(0, DW - 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
